map_query_arbiter: RTL

Time-shares one combinational `mapRom` lookup port among `NREQ` movement requesters: the pacman and the three monsters. Without it, each requester needs its own bank of wall-check `mapRom` instances. Each requester posts a map-relative (x, y) coordinate and receives the 2-bit map pixel with a one-cycle `ack` pulse. The block sits between the pacman/monster movement logic and a single `mapRom`, on the 50 MHz system clock.

---
 rtl/map_query_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/map_query_arbiter.sv
// Round-robin arbiter sharing one combinational mapRom port among NREQ movement requesters.
// Optional macro MAP_ARB_PACMAN_PRIO_EN gives requester 0 (pacman) strict priority.
module map_query_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 9,
  parameter int DW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_x,
  input  logic [NREQ*AW-1:0] req_y,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rsp_pixel,
  output logic              busy,
  output logic [AW-1:0]     rom_x,
  output logic [AW-1:0]     rom_y,
  input  logic [DW-1:0]     rom_pixel
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef MAP_ARB_PACMAN_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            grant_s;
  logic [GW-1:0]   pick_s;
  logic [GW-1:0]   last_r;
  logic [GW-1:0]   gnt_r;
  logic            busy_r;

  // Search ascending from last+1 with wrap; with priority, 0 is excluded from the rotation
  // and wins outright whenever it requests.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [GW-1:0] l);
    logic [GW-1:0] g;
    logic          found;
    int            idx;
    g     = l;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(l) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && r[idx] && !(PRIO_EN && (idx == 0))) begin
        g     = GW'(idx);
        found = 1'b1;
      end
    end
    if (PRIO_EN && r[0]) begin
      g = '0;
    end
    return g;
  endfunction

  // Next-state decode and grant decision (arbitration only in IDLE).
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    pick_s  = rr_pick(req, last_r);
    case (state_r)
      IDLE: begin
        if (!hold && (req != '0)) begin
          grant_s = 1'b1;
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Address capture on grant, response capture in ADDR; ack is a single-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_x     <= '0;
      rom_y     <= '0;
      gnt_r     <= '0;
      last_r    <= GW'(NREQ - 1);
      ack       <= '0;
      rsp_pixel <= '0;
    end else begin
      if (grant_s) begin
        rom_x <= req_x[pick_s*AW +: AW];
        rom_y <= req_y[pick_s*AW +: AW];
        gnt_r <= pick_s;
        // Pacman grants under priority leave the monster rotation pointer untouched
        if (!(PRIO_EN && (pick_s == '0))) begin
          last_r <= pick_s;
        end
      end
      if (state_r == ADDR) begin
        rsp_pixel <= rom_pixel;
        ack       <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_r;
      end else begin
        ack <= '0;
      end
    end
  end

  assign busy = busy_r;

endmodule
